// File: rtl/prim_assembler.sv
// rtl/prim_assembler.sv - triangle assembler with buffered output queue
//
// Accepts vertex-state register writes, assembles LIST/STRIP/FAN triangles
// and queues them for the rasterizer.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         register write handshake (cmd_addr, cmd_wdata)
//   tri_valid/tri_ready         triangle handshake, head of output queue
//   tri_x/tri_y/tri_z/tri_color packed {v2,v1,v0} vertex attributes
//   tri_inv_area                1/area of the head triangle (0.16 fixed)
//   prim_mode, vtx_count        current topology and pending vertex count
//   queue_level, tri_emitted    queued triangles, total triangles pushed
module prim_assembler #(
  parameter int XY_W      = 16,
  parameter int Z_W       = 25,
  parameter int COLOR_W   = 32,
  parameter int OUT_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [6:0]                   cmd_addr,
  input  logic [63:0]                  cmd_wdata,
  output logic                         tri_valid,
  input  logic                         tri_ready,
  output logic [3*XY_W-1:0]            tri_x,
  output logic [3*XY_W-1:0]            tri_y,
  output logic [3*Z_W-1:0]             tri_z,
  output logic [3*COLOR_W-1:0]         tri_color,
  output logic [15:0]                  tri_inv_area,
  output logic [1:0]                   prim_mode,
  output logic [1:0]                   vtx_count,
  output logic [$clog2(OUT_DEPTH):0]   queue_level,
  output logic [31:0]                  tri_emitted
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int LW = PW + 1;
  // Vertex bundle layout: {color, z, y, x}
  localparam int VW = 2*XY_W + Z_W + COLOR_W;
  localparam logic [LW-1:0] FULL = LW'(OUT_DEPTH);

  localparam logic [6:0] A_COLOR   = 7'h00;
  localparam logic [6:0] A_VERTEX  = 7'h02;
  localparam logic [6:0] A_INVAREA = 7'h03;
  localparam logic [6:0] A_MODE    = 7'h0C;
  localparam logic [6:0] A_RESTART = 7'h0D;

  logic [1:0]         prim_mode_q;
  logic [1:0]         vtx_count_q, vtx_count_d;
  logic               parity_q, parity_d;
  logic [VW-1:0]      a_q, a_d, b_q, b_d;
  logic [COLOR_W-1:0] color_q;
  logic [15:0]        inv_q;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]      level_q;
  logic [31:0]        emitted_q;

  logic [3*XY_W-1:0]    qx_q   [OUT_DEPTH];
  logic [3*XY_W-1:0]    qy_q   [OUT_DEPTH];
  logic [3*Z_W-1:0]     qz_q   [OUT_DEPTH];
  logic [3*COLOR_W-1:0] qc_q   [OUT_DEPTH];
  logic [15:0]          qinv_q [OUT_DEPTH];

  logic          wr_en, is_vtx, restart, emit, pop;
  logic [VW-1:0] new_vtx, v0, v1, v2;
  logic          unused_wdata;

  assign unused_wdata = ^cmd_wdata;

  assign wr_en   = cmd_valid && cmd_ready;
  assign is_vtx  = wr_en && (cmd_addr == A_VERTEX);
  assign restart = wr_en && ((cmd_addr == A_MODE) || (cmd_addr == A_RESTART));
  assign new_vtx = {color_q, cmd_wdata[32 +: Z_W], cmd_wdata[16 +: XY_W], cmd_wdata[XY_W-1:0]};
  assign pop     = tri_valid && tri_ready;

  // Slot update and emit selection for the incoming vertex
  always_comb begin
    vtx_count_d = vtx_count_q;
    parity_d    = parity_q;
    a_d         = a_q;
    b_d         = b_q;
    emit        = 1'b0;
    v0          = a_q;
    v1          = b_q;
    v2          = new_vtx;
    if (restart) begin
      vtx_count_d = 2'd0;
      parity_d    = 1'b0;
    end else if (is_vtx) begin
      case (vtx_count_q)
        2'd0: begin
          a_d         = new_vtx;
          vtx_count_d = 2'd1;
        end
        2'd1: begin
          b_d         = new_vtx;
          vtx_count_d = 2'd2;
        end
        default: begin
          emit = 1'b1;
          case (prim_mode_q)
            2'd1: begin
              // Odd strip triangles swap the first two vertices to keep winding
              if (parity_q) begin
                v0 = b_q;
                v1 = a_q;
              end
              a_d      = b_q;
              b_d      = new_vtx;
              parity_d = ~parity_q;
            end
            2'd2: b_d = new_vtx;
            default: vtx_count_d = 2'd0;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prim_mode_q <= 2'd0;
      vtx_count_q <= 2'd0;
      parity_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      color_q     <= '1;
      inv_q       <= 16'hFFFF;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      emitted_q   <= '0;
    end else begin
      vtx_count_q <= vtx_count_d;
      parity_q    <= parity_d;
      a_q         <= a_d;
      b_q         <= b_d;
      if (wr_en && cmd_addr == A_COLOR)   color_q     <= cmd_wdata[COLOR_W-1:0];
      if (wr_en && cmd_addr == A_INVAREA) inv_q       <= cmd_wdata[15:0];
      if (wr_en && cmd_addr == A_MODE)    prim_mode_q <= cmd_wdata[1:0];
      if (emit) begin
        wr_ptr_q  <= wr_ptr_q + 1'b1;
        emitted_q <= emitted_q + 32'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({emit, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        qx_q[i]   <= '0;
        qy_q[i]   <= '0;
        qz_q[i]   <= '0;
        qc_q[i]   <= '0;
        qinv_q[i] <= '0;
      end
    end else if (emit) begin
      qx_q[wr_ptr_q]   <= {v2[XY_W-1:0], v1[XY_W-1:0], v0[XY_W-1:0]};
      qy_q[wr_ptr_q]   <= {v2[2*XY_W-1:XY_W], v1[2*XY_W-1:XY_W], v0[2*XY_W-1:XY_W]};
      qz_q[wr_ptr_q]   <= {v2[2*XY_W +: Z_W], v1[2*XY_W +: Z_W], v0[2*XY_W +: Z_W]};
      qc_q[wr_ptr_q]   <= {v2[VW-1 -: COLOR_W], v1[VW-1 -: COLOR_W], v0[VW-1 -: COLOR_W]};
      qinv_q[wr_ptr_q] <= inv_q;
    end
  end

  assign cmd_ready    = (level_q != FULL);
  assign tri_valid    = (level_q != '0);
  assign tri_x        = qx_q[rd_ptr_q];
  assign tri_y        = qy_q[rd_ptr_q];
  assign tri_z        = qz_q[rd_ptr_q];
  assign tri_color    = qc_q[rd_ptr_q];
  assign tri_inv_area = qinv_q[rd_ptr_q];
  assign prim_mode    = prim_mode_q;
  assign vtx_count    = vtx_count_q;
  assign queue_level  = level_q;
  assign tri_emitted  = emitted_q;

endmodule

// File: tb/tb_prim_assembler.sv
// tb/tb_prim_assembler.sv - directed scoreboard bench for prim_assembler
module tb_prim_assembler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [6:0]   cmd_addr;
  logic [63:0]  cmd_wdata;
  logic         tri_valid;
  logic         tri_ready;
  logic [47:0]  tri_x, tri_y;
  logic [74:0]  tri_z;
  logic [95:0]  tri_color;
  logic [15:0]  tri_inv_area;
  logic [1:0]   prim_mode, vtx_count;
  logic [2:0]   queue_level;
  logic [31:0]  tri_emitted;

  typedef struct {
    logic [47:0] x, y;
    logic [74:0] z;
    logic [95:0] c;
    logic [15:0] inv;
  } tri_t;

  tri_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_color;
  logic [15:0] cur_inv;

  prim_assembler dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_x(tri_x), .tri_y(tri_y), .tri_z(tri_z), .tri_color(tri_color),
    .tri_inv_area(tri_inv_area), .prim_mode(prim_mode), .vtx_count(vtx_count),
    .queue_level(queue_level), .tri_emitted(tri_emitted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fy(input logic [15:0] x);
    return x ^ 16'hA5A5;
  endfunction

  function automatic logic [24:0] fz(input logic [15:0] x);
    return {9'h15A, x};
  endfunction

  function automatic logic [63:0] vdata(input logic [15:0] x);
    return {7'b0, fz(x), fy(x), x};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [63:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = d;
    #1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    assert (n < 200) else begin
      errors++;
      $error("FAIL wr_timeout observed=%0d expected=<200", n);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic vtx(input logic [15:0] x);
    wr(7'h02, vdata(x));
  endtask

  task automatic exp3(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2);
    tri_t t;
    t.x   = {x2, x1, x0};
    t.y   = {fy(x2), fy(x1), fy(x0)};
    t.z   = {fz(x2), fz(x1), fz(x0)};
    t.c   = {3{cur_color}};
    t.inv = cur_inv;
    exp_q.push_back(t);
  endtask

  task automatic drain();
    int n = 0;
    tri_ready = 1'b1;
    while ((exp_q.size() != 0 || tri_valid) && n < 100) begin
      @(negedge clk); #2; n++;
    end
    chk("drain_empty", {126'b0, exp_q.size() == 0, !tri_valid}, 128'd3);
  endtask

  // Scoreboard: a pop happens on the next posedge whenever valid && ready here
  always @(negedge clk) begin
    #1;
    if (rst_n && tri_valid && tri_ready) begin
      chk("pop_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        tri_t t;
        t = exp_q.pop_front();
        chk("tri_x", tri_x, t.x);
        chk("tri_y", tri_y, t.y);
        chk("tri_z", tri_z, t.z);
        chk("tri_color", tri_color, t.c);
        chk("tri_inv_area", tri_inv_area, t.inv);
      end
    end
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; tri_ready = 1'b0;
    cur_color = 32'hFFFF_FFFF; cur_inv = 16'hFFFF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_tri_valid", tri_valid, 0);
    chk("rst_tri_x", tri_x, 0);
    chk("rst_tri_inv", tri_inv_area, 0);
    chk("rst_prim_mode", prim_mode, 0);
    chk("rst_vtx_count", vtx_count, 0);
    chk("rst_level", queue_level, 0);
    chk("rst_emitted", tri_emitted, 0);
    @(negedge clk); rst_n = 1'b1;

    // LIST with single-cycle latency
    tri_ready = 1'b1;
    cur_color = 32'hFF00_00FF; wr(7'h00, {32'h0, cur_color});
    cur_inv = 16'h1234;        wr(7'h03, {48'h0, cur_inv});
    vtx(16'h0010); vtx(16'h0100);
    exp3(16'h0010, 16'h0100, 16'h0080);
    vtx(16'h0080);
    chk("list_valid_t1", tri_valid, 1);
    chk("list_tri_x", tri_x, {16'h0080, 16'h0100, 16'h0010});
    chk("list_color", tri_color, {3{32'hFF00_00FF}});
    chk("list_emitted", tri_emitted, 1);
    chk("list_vtx_count", vtx_count, 0);
    drain();

    // STRIP
    wr(7'h0C, 64'd1);
    vtx(1); vtx(2);
    exp3(1, 2, 3); vtx(3);
    exp3(3, 2, 4); vtx(4);
    exp3(3, 4, 5); vtx(5);
    chk("strip_vtx_count", vtx_count, 2);
    chk("strip_mode", prim_mode, 1);
    drain();
    chk("strip_emitted", tri_emitted, 4);

    // FAN
    wr(7'h0C, 64'd2);
    chk("fan_restart", vtx_count, 0);
    vtx(10); vtx(11);
    exp3(10, 11, 12); vtx(12);
    exp3(10, 12, 13); vtx(13);
    drain();
    chk("fan_emitted", tri_emitted, 6);

    // Back-pressure with stalled rasterizer
    wr(7'h0C, 64'd0);
    tri_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      vtx(16'h100 + 16'(3*t)); vtx(16'h101 + 16'(3*t));
      exp3(16'h100 + 16'(3*t), 16'h101 + 16'(3*t), 16'h102 + 16'(3*t));
      vtx(16'h102 + 16'(3*t));
    end
    chk("bp_level_full", queue_level, 4);
    chk("bp_cmd_ready_low", cmd_ready, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 7'h02; cmd_wdata = vdata(16'h10C);
    repeat (3) @(negedge clk);
    #1;
    chk("bp_held_vtx", vtx_count, 0);
    chk("bp_held_level", queue_level, 4);
    @(negedge clk); tri_ready = 1'b1;
    @(negedge clk); tri_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp_accept_vtx", vtx_count, 1);
    chk("bp_accept_level", queue_level, 3);
    vtx(16'h10D);
    exp3(16'h10C, 16'h10D, 16'h10E);
    vtx(16'h10E);
    chk("bp_refill_level", queue_level, 4);
    tri_ready = 1'b1;
    vtx(16'h10F); vtx(16'h110);
    exp3(16'h10F, 16'h110, 16'h111);
    vtx(16'h111);
    drain();
    chk("bp_emitted", tri_emitted, 12);

    // Simultaneous push and pop at level 2
    tri_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      vtx(16'h200 + 16'(3*t)); vtx(16'h201 + 16'(3*t));
      exp3(16'h200 + 16'(3*t), 16'h201 + 16'(3*t), 16'h202 + 16'(3*t));
      vtx(16'h202 + 16'(3*t));
    end
    chk("pp_level_before", queue_level, 2);
    vtx(16'h210); vtx(16'h211);
    exp3(16'h210, 16'h211, 16'h212);
    @(negedge clk);
    tri_ready = 1'b1; cmd_valid = 1'b1; cmd_addr = 7'h02; cmd_wdata = vdata(16'h212);
    @(posedge clk); #1;
    cmd_valid = 1'b0; tri_ready = 1'b0;
    chk("pp_level_same", queue_level, 2);
    drain();

    // PRIM_RESTART discards the pending vertex
    vtx(16'h7777);
    chk("rs_pending", vtx_count, 1);
    wr(7'h0D, 64'd0);
    chk("rs_cleared", vtx_count, 0);
    vtx(16'h20); vtx(16'h21);
    exp3(16'h20, 16'h21, 16'h22);
    vtx(16'h22);
    drain();

    // Asynchronous reset mid-stream
    tri_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      vtx(16'h300 + 16'(3*t)); vtx(16'h301 + 16'(3*t));
      exp3(16'h300 + 16'(3*t), 16'h301 + 16'(3*t), 16'h302 + 16'(3*t));
      vtx(16'h302 + 16'(3*t));
    end
    vtx(16'h310); vtx(16'h311);
    chk("ar_level", queue_level, 3);
    chk("ar_vtx", vtx_count, 2);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("ar_tri_valid", tri_valid, 0);
    chk("ar_level0", queue_level, 0);
    chk("ar_emitted0", tri_emitted, 0);
    chk("ar_cmd_ready", cmd_ready, 1);
    chk("ar_vtx0", vtx_count, 0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    cur_color = 32'hFFFF_FFFF; cur_inv = 16'hFFFF;
    tri_ready = 1'b1;
    vtx(16'h40); vtx(16'h41);
    exp3(16'h40, 16'h41, 16'h42);
    vtx(16'h42);
    chk("ar_post_inv", tri_inv_area, 16'hFFFF);
    drain();
    chk("ar_post_emitted", tri_emitted, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
